fechadura_ctrl: RTL and testbench

Main operating controller of the electronic lock. Sequences the lock bolt through its locked, unlocked and door-open phases. Checks keypad entries against the master password and the four user passwords, enforces a lockout after repeated errors, and hands the keypad over to the `setup` block when configuration is requested. Sits between the keypad/digit collector, the `setup` block and the bolt/buzzer drivers.

---
 rtl/Tipos.sv | 29 ++
 rtl/fechadura_ctrl_pkg.sv | 43 ++++
 rtl/fechadura_ctrl_if.sv | 31 +++
 rtl/fechadura_ctrl_temporizador_seg.sv | 49 ++++
 rtl/fechadura_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fechadura_ctrl.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/Tipos.sv
// Shared lock types: entered-password packet, setup packet, controller state
// encoding and the "empty password" constant.
package Tipos;

    // Eight BCD digits; unused nibbles are 4'hF.
    typedef logic [31:0] senhaPac_t;

    localparam senhaPac_t SENHA_VAZIA = 32'hFFFF_FFFF;

    typedef struct packed {
        logic       bip_status;
        logic [5:0] bip_time;
        logic [5:0] tranca_aut_time;
        senhaPac_t  master;
        senhaPac_t  senha_1;
        senhaPac_t  senha_2;
        senhaPac_t  senha_3;
        senhaPac_t  senha_4;
    } setupPac_t;

    typedef enum logic [2:0] {
        TRANCADA,
        DESTRANCADA,
        PORTA_ABERTA,
        BLOQUEIO,
        SETUP
    } ctrlEstado_t;

endpackage

// File: rtl/fechadura_ctrl_pkg.sv
// Controller helpers: reset configuration, password match and time-field
// normalisation.
package fechadura_ctrl_pkg;
    import Tipos::*;

    localparam setupPac_t CFG_RESET = '{
        bip_status:      1'b1,
        bip_time:        6'd5,
        tranca_aut_time: 6'd5,
        master:          32'hFFFF_1234,
        senha_1:         SENHA_VAZIA,
        senha_2:         SENHA_VAZIA,
        senha_3:         SENHA_VAZIA,
        senha_4:         SENHA_VAZIA
    };

    // A zero-second setting would never expire; treat it as one second.
    function automatic logic [5:0] seg_efetivo(input logic [5:0] t);
        return (t == 6'd0) ? 6'd1 : t;
    endfunction

    // True on the last cycle of the alvo-th second spent in the state.
    function automatic logic expirou(input logic tick, input logic [5:0] seg,
                                     input logic [5:0] alvo);
        return tick && (seg == (seg_efetivo(alvo) - 6'd1));
    endfunction

    // An all-F slot is disabled.
    function automatic logic slot_confere(input senhaPac_t entrada, input senhaPac_t slot);
        return (slot != SENHA_VAZIA) && (entrada == slot);
    endfunction

    function automatic logic senha_confere(input senhaPac_t entrada, input setupPac_t cfg);
        if (entrada == SENHA_VAZIA)
            return 1'b0;
        return slot_confere(entrada, cfg.master)  ||
               slot_confere(entrada, cfg.senha_1) ||
               slot_confere(entrada, cfg.senha_2) ||
               slot_confere(entrada, cfg.senha_3) ||
               slot_confere(entrada, cfg.senha_4);
    endfunction

endpackage

// File: rtl/fechadura_ctrl_if.sv
// Signal bundle between the lock controller and keypad/setup/bolt drivers.
interface fechadura_ctrl_if;
    import Tipos::*;

    senhaPac_t digitos_value;
    logic      digitos_valid;
    logic      cmd_setup;
    logic      botao_interno;
    logic      sensor_porta;
    setupPac_t data_setup_new;
    logic      data_setup_ok;
    logic      setup_on;
    logic      tranca;
    logic      bip;
    logic      senha_ok;
    logic      senha_erro;
    logic      bloqueado;

    modport master (
        output digitos_value, digitos_valid, cmd_setup, botao_interno,
               sensor_porta, data_setup_new, data_setup_ok,
        input  setup_on, tranca, bip, senha_ok, senha_erro, bloqueado
    );

    modport slave (
        input  digitos_value, digitos_valid, cmd_setup, botao_interno,
               sensor_porta, data_setup_new, data_setup_ok,
        output setup_on, tranca, bip, senha_ok, senha_erro, bloqueado
    );

endinterface

// File: rtl/fechadura_ctrl_temporizador_seg.sv
// Prescaler plus saturating 6-bit seconds counter. clr restarts both;
// tick marks the last cycle of each second.
module temporizador_seg #(
    parameter int TICK_CICLOS = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    output logic [5:0] seg,
    output logic       tick
);

    localparam int            PW        = (TICK_CICLOS > 1) ? $clog2(TICK_CICLOS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CICLOS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    seg_q, seg_d;

    assign tick = (presc_q == PRESC_MAX);
    assign seg  = seg_q;

    // Next prescaler / seconds value; seconds hold at 63 instead of wrapping.
    always_comb begin
        presc_d = presc_q;
        seg_d   = seg_q;
        if (clr) begin
            presc_d = '0;
            seg_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            if (seg_q != 6'd63)
                seg_d = seg_q + 6'd1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            seg_q   <= '0;
        end else begin
            presc_q <= presc_d;
            seg_q   <= seg_d;
        end
    end

endmodule

// File: rtl/fechadura_ctrl.sv
// Electronic lock main controller: bolt sequencing, password check,
// lockout after repeated errors and hand-over to the setup block.
// Optional lockout feature: FECHADURA_BLOQUEIO_EN (error counter, BLOQUEIO
// state and bloqueado output); when undefined wrong entries only pulse
// senha_erro and bloqueado stays 0.
module fechadura_ctrl
    import Tipos::*, fechadura_ctrl_pkg::*;
#(
    parameter int TICK_CICLOS = 50_000_000,
    parameter int MAX_ERROS   = 3,
    parameter int BLOQUEIO_S  = 30
) (
    input  logic              clk,
    input  logic              rst,
    fechadura_ctrl_if.slave   bus
);

    ctrlEstado_t estado_q, estado_d;
    setupPac_t   cfg_q, cfg_d;
    logic        tranca_q, tranca_d;
    logic        setup_on_q, setup_on_d;
    logic        bip_q, bip_d;
    logic        senha_ok_q, senha_ok_d;
    logic        senha_erro_q, senha_erro_d;
    logic        confere;
    logic        clr;
    logic [5:0]  seg;
    logic        tick;

`ifdef FECHADURA_BLOQUEIO_EN
    localparam int               ERR_W    = $clog2(MAX_ERROS + 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(MAX_ERROS);
    localparam logic [5:0]       BLOQ_SEG = 6'(BLOQUEIO_S);

    logic [ERR_W-1:0] erros_q, erros_d, erros_inc;
    logic             bloqueado_q, bloqueado_d;

    assign erros_inc = (erros_q >= ERR_MAX) ? ERR_MAX : erros_q + 1'b1;
`endif

    assign confere = senha_confere(bus.digitos_value, cfg_q);

    // Any state change restarts the prescaler and second counter.
    assign clr = (estado_d != estado_q);

    temporizador_seg #(.TICK_CICLOS(TICK_CICLOS)) u_temporizador (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .seg  (seg),
        .tick (tick)
    );

    // Next state, pulses, shadow configuration and registered output values.
    always_comb begin
        estado_d     = estado_q;
        senha_ok_d   = 1'b0;
        senha_erro_d = 1'b0;
        cfg_d        = bus.data_setup_ok ? bus.data_setup_new : cfg_q;
`ifdef FECHADURA_BLOQUEIO_EN
        erros_d      = erros_q;
`endif
        case (estado_q)
            TRANCADA: begin
                if (bus.botao_interno) begin
                    estado_d = DESTRANCADA;
                end else if (bus.cmd_setup) begin
                    estado_d = SETUP;
                end else if (bus.digitos_valid) begin
                    if (confere) begin
                        estado_d   = DESTRANCADA;
                        senha_ok_d = 1'b1;
`ifdef FECHADURA_BLOQUEIO_EN
                        erros_d    = '0;
`endif
                    end else begin
                        senha_erro_d = 1'b1;
`ifdef FECHADURA_BLOQUEIO_EN
                        erros_d = erros_inc;
                        if (erros_inc == ERR_MAX)
                            estado_d = BLOQUEIO;
`endif
                    end
                end
            end
            DESTRANCADA: begin
                if (bus.sensor_porta)
                    estado_d = PORTA_ABERTA;
                else if (expirou(tick, seg, cfg_q.tranca_aut_time))
                    estado_d = TRANCADA;
            end
            PORTA_ABERTA: begin
                if (!bus.sensor_porta)
                    estado_d = DESTRANCADA;
            end
`ifdef FECHADURA_BLOQUEIO_EN
            BLOQUEIO: begin
                if (bus.botao_interno) begin
                    estado_d = DESTRANCADA;
                    erros_d  = '0;
                end else if (expirou(tick, seg, BLOQ_SEG)) begin
                    estado_d = TRANCADA;
                    erros_d  = '0;
                end
            end
`endif
            SETUP: begin
                if (bus.data_setup_ok)
                    estado_d = TRANCADA;
            end
            default: estado_d = TRANCADA;
        endcase

        tranca_d   = !((estado_d == DESTRANCADA) || (estado_d == PORTA_ABERTA));
        setup_on_d = (estado_d == SETUP);
        // Buzzer rises on the edge where the open time reaches bip_time.
        bip_d      = (estado_q == PORTA_ABERTA) && (estado_d == PORTA_ABERTA) &&
                     cfg_q.bip_status &&
                     ((seg >= seg_efetivo(cfg_q.bip_time)) ||
                      expirou(tick, seg, cfg_q.bip_time));
`ifdef FECHADURA_BLOQUEIO_EN
        bloqueado_d = (estado_d == BLOQUEIO);
`endif
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q     <= TRANCADA;
            cfg_q        <= CFG_RESET;
            tranca_q     <= 1'b1;
            setup_on_q   <= 1'b0;
            bip_q        <= 1'b0;
            senha_ok_q   <= 1'b0;
            senha_erro_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cfg_q        <= cfg_d;
            tranca_q     <= tranca_d;
            setup_on_q   <= setup_on_d;
            bip_q        <= bip_d;
            senha_ok_q   <= senha_ok_d;
            senha_erro_q <= senha_erro_d;
        end
    end

`ifdef FECHADURA_BLOQUEIO_EN
    // Error counter and lockout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            erros_q     <= '0;
            bloqueado_q <= 1'b0;
        end else begin
            erros_q     <= erros_d;
            bloqueado_q <= bloqueado_d;
        end
    end

    assign bus.bloqueado = bloqueado_q;
`else
    assign bus.bloqueado = 1'b0;
`endif

    assign bus.tranca     = tranca_q;
    assign bus.setup_on   = setup_on_q;
    assign bus.bip        = bip_q;
    assign bus.senha_ok   = senha_ok_q;
    assign bus.senha_erro = senha_erro_q;

endmodule

// File: tb/tb_fechadura_ctrl.sv
// Directed bench for fechadura_ctrl with an entry-result scoreboard.
`timescale 1ns/1ps
module tb_fechadura_ctrl;
    import Tipos::*;

    localparam int TICK = 10;

    typedef struct packed {
        logic ok;
        logic erro;
    } resp_t;

    logic      clk = 1'b0;
    logic      rst;
    int        total = 0;
    int        bad   = 0;
    resp_t     sb[$];
    setupPac_t cfg;

    always #5 clk = ~clk;

    fechadura_ctrl_if bus();

    fechadura_ctrl #(
        .TICK_CICLOS (TICK),
        .MAX_ERROS   (3),
        .BLOQUEIO_S  (30)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one entry for one cycle, then score the pulses it produced.
    task automatic entry(input string tag, input senhaPac_t v, input logic ok, input logic erro);
        resp_t r;
        bus.digitos_value = v;
        bus.digitos_valid = 1'b1;
        sb.push_back('{ok: ok, erro: erro});
        step();
        bus.digitos_valid = 1'b0;
        bus.digitos_value = SENHA_VAZIA;
        r = sb.pop_front();
        chk({tag, "_ok"},   bus.senha_ok,   r.ok);
        chk({tag, "_erro"}, bus.senha_erro, r.erro);
    endtask

    // Bolt must stay open for n-1 more cycles and close on the n-th.
    task automatic expect_lock_at(input string tag, input int n);
        for (int i = 1; i < n; i++) step();
        chk({tag, "_still_open"}, bus.tranca, 1'b0);
        step();
        chk({tag, "_locked"}, bus.tranca, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t r;
        rst                = 1'b0;
        bus.digitos_value  = SENHA_VAZIA;
        bus.digitos_valid  = 1'b0;
        bus.cmd_setup      = 1'b0;
        bus.botao_interno  = 1'b0;
        bus.sensor_porta   = 1'b0;
        bus.data_setup_new = '0;
        bus.data_setup_ok  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tranca",     bus.tranca,     1'b1);
        chk("rst_setup_on",   bus.setup_on,   1'b0);
        chk("rst_bip",        bus.bip,        1'b0);
        chk("rst_senha_ok",   bus.senha_ok,   1'b0);
        chk("rst_senha_erro", bus.senha_erro, 1'b0);
        chk("rst_bloqueado",  bus.bloqueado,  1'b0);
        rst = 1'b1;
        step();

        // Default master unlocks; auto-lock after 5 s.
        entry("t1_master", 32'hFFFF_1234, 1'b1, 1'b0);
        chk("t1_tranca", bus.tranca, 1'b0);
        step();
        chk("t1_ok_single", bus.senha_ok, 1'b0);
        expect_lock_at("t2_autolock", 49);

        // Three wrong entries.
        entry("t3_err1", 32'hFFFF_9999, 1'b0, 1'b1);
        entry("t3_err2", 32'hFFFF_9999, 1'b0, 1'b1);
        entry("t3_err3", 32'hFFFF_9999, 1'b0, 1'b1);
`ifdef FECHADURA_BLOQUEIO_EN
        chk("t3_bloq_on", bus.bloqueado, 1'b1);
        entry("t3_ignored", 32'hFFFF_1234, 1'b0, 1'b0);
        chk("t3_bloq_tranca", bus.tranca, 1'b1);
        for (int i = 2; i < 300; i++) step();
        chk("t3_bloq_hold", bus.bloqueado, 1'b1);
        step();
        chk("t3_bloq_off", bus.bloqueado, 1'b0);
        chk("t3_bloq_exit_tranca", bus.tranca, 1'b1);
        entry("t3_cnt_cleared", 32'hFFFF_9999, 1'b0, 1'b1);
        chk("t3_no_relock", bus.bloqueado, 1'b0);
`else
        chk("t3_no_bloq", bus.bloqueado, 1'b0);
        entry("t3_after_err", 32'hFFFF_1234, 1'b1, 1'b0);
        expect_lock_at("t3_relock", 50);
`endif

        // Door open 6 s: buzzer from second 5, auto-lock restarts on close.
        entry("t4_unlock", 32'hFFFF_1234, 1'b1, 1'b0);
        bus.sensor_porta = 1'b1;
        step();
        chk("t4_open_tranca", bus.tranca, 1'b0);
        chk("t4_bip_early", bus.bip, 1'b0);
        for (int i = 1; i < 50; i++) step();
        chk("t4_bip_before5", bus.bip, 1'b0);
        step();
        chk("t4_bip_at5", bus.bip, 1'b1);
        repeat (10) step();
        chk("t4_bip_at6", bus.bip, 1'b1);
        bus.sensor_porta = 1'b0;
        step();
        chk("t4_bip_closed", bus.bip, 1'b0);
        expect_lock_at("t4_relock", 50);

        // Setup: new master 5678, auto-lock time 0 (acts as 1 s).
        bus.cmd_setup = 1'b1;
        step();
        bus.cmd_setup = 1'b0;
        chk("t5_setup_on", bus.setup_on, 1'b1);
        chk("t5_setup_tranca", bus.tranca, 1'b1);
        entry("t5_digits_ignored", 32'hFFFF_1234, 1'b0, 1'b0);
        chk("t5_still_setup", bus.setup_on, 1'b1);
        cfg.bip_status      = 1'b1;
        cfg.bip_time        = 6'd5;
        cfg.tranca_aut_time = 6'd0;
        cfg.master          = 32'hFFFF_5678;
        cfg.senha_1         = SENHA_VAZIA;
        cfg.senha_2         = SENHA_VAZIA;
        cfg.senha_3         = SENHA_VAZIA;
        cfg.senha_4         = SENHA_VAZIA;
        bus.data_setup_new  = cfg;
        bus.data_setup_ok   = 1'b1;
        step();
        bus.data_setup_ok   = 1'b0;
        chk("t5_setup_off", bus.setup_on, 1'b0);
        entry("t5_old_rejected", 32'hFFFF_1234, 1'b0, 1'b1);
        entry("t5_new_accepted", 32'hFFFF_5678, 1'b1, 1'b0);
        expect_lock_at("t5_zero_time", 10);

        // Button and wrong entry in the same cycle: button wins.
        entry("t6_err1", 32'hFFFF_9999, 1'b0, 1'b1);
        entry("t6_err2", 32'hFFFF_9999, 1'b0, 1'b1);
        bus.digitos_value = 32'hFFFF_9999;
        bus.digitos_valid = 1'b1;
        bus.botao_interno = 1'b1;
        sb.push_back('{ok: 1'b0, erro: 1'b0});
        step();
        bus.digitos_valid = 1'b0;
        bus.botao_interno = 1'b0;
        bus.digitos_value = SENHA_VAZIA;
        r = sb.pop_front();
        chk("t6_prio_ok",   bus.senha_ok,   r.ok);
        chk("t6_prio_erro", bus.senha_erro, r.erro);
        chk("t6_prio_tranca", bus.tranca, 1'b0);
        expect_lock_at("t6_relock", 10);
        entry("t6_err3", 32'hFFFF_9999, 1'b0, 1'b1);
`ifdef FECHADURA_BLOQUEIO_EN
        chk("t6_cnt_kept", bus.bloqueado, 1'b1);
`else
        chk("t6_no_bloq", bus.bloqueado, 1'b0);
`endif

        // Button opens; asynchronous reset mid-operation restores defaults.
        bus.botao_interno = 1'b1;
        step();
        bus.botao_interno = 1'b0;
        chk("t7_btn_tranca", bus.tranca, 1'b0);
        chk("t7_btn_bloq", bus.bloqueado, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("t7_async_tranca", bus.tranca, 1'b1);
        chk("t7_async_bloq", bus.bloqueado, 1'b0);
        step();
        rst = 1'b1;
        step();
        entry("t7_cfg_reset", 32'hFFFF_1234, 1'b1, 1'b0);
        chk("t7_cfg_tranca", bus.tranca, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
